// File: rtl/conv_weight_loader_if.sv
// Weight-stream and window-fetch signals between streamer, loader and PE array.
// The loader takes the slave modport; the stream carries no backpressure.
interface conv_weight_loader_if #(
   parameter int DATA_WIDTH   = 16,
   parameter int IN_CHANNELS  = 4,
   parameter int OUT_CHANNELS = 64,
   parameter int KERNEL_SIZE  = 3
);
   localparam int KERNEL_ELEM_NUM = KERNEL_SIZE * KERNEL_SIZE;
   localparam int OC_W            = $clog2(OUT_CHANNELS);
   localparam int IC_W            = $clog2(IN_CHANNELS);

   logic                                   load_start;
   logic                                   start_stream;
   logic                                   weight_valid;
   logic signed [DATA_WIDTH-1:0]           weight_data;
   logic                                   loaded;
   logic                                   load_busy;
   logic                                   err_timeout;
   logic                                   err_overflow;
   logic                                   rd_req;
   logic [OC_W-1:0]                        rd_oc;
   logic [IC_W-1:0]                        rd_ic;
   logic                                   rd_ready;
   logic                                   win_valid;
   logic [KERNEL_ELEM_NUM*DATA_WIDTH-1:0]  win_data;

   modport slave (
      input  load_start, weight_valid, weight_data, rd_req, rd_oc, rd_ic,
      output start_stream, loaded, load_busy, err_timeout, err_overflow,
             rd_ready, win_valid, win_data
   );

   modport master (
      output load_start, weight_valid, weight_data, rd_req, rd_oc, rd_ic,
      input  start_stream, loaded, load_busy, err_timeout, err_overflow,
             rd_ready, win_valid, win_data
   );
endinterface

// File: rtl/conv_weight_loader.sv
// Captures the full conv weight stream into local RAM, then serves one kernel window per request.
// Window returns 10 cycles after accept; stream has no backpressure, fetches gated by rd_ready.
module conv_weight_loader #(
   parameter int DATA_WIDTH    = 16,
   parameter int IN_CHANNELS   = 4,
   parameter int OUT_CHANNELS  = 64,
   parameter int KERNEL_SIZE   = 3,
   parameter int START_TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   conv_weight_loader_if.slave  bus
);
   localparam int KERNEL_ELEM_NUM = KERNEL_SIZE * KERNEL_SIZE;
   localparam int MEM_DEPTH       = OUT_CHANNELS * IN_CHANNELS * KERNEL_ELEM_NUM;
   localparam int ADDR_WIDTH      = $clog2(MEM_DEPTH);
   localparam int IDLE_W          = $clog2(START_TIMEOUT + 1);
   localparam int TAP_W           = $clog2(KERNEL_ELEM_NUM);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(MEM_DEPTH - 1);
   localparam logic [IDLE_W-1:0]     IDLE_LIMIT = IDLE_W'(START_TIMEOUT - 1);
   localparam logic [TAP_W-1:0]      LAST_TAP   = TAP_W'(KERNEL_ELEM_NUM - 1);

   typedef enum logic [1:0] {L_IDLE, L_REQ, L_RECV, L_DONE} load_state_t;
   typedef enum logic [1:0] {F_IDLE, F_ISSUE, F_DRAIN, F_DONE} fetch_state_t;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
   logic [DATA_WIDTH-1:0] ram_q;

   load_state_t           lstate;
   logic [ADDR_WIDTH-1:0] word_cnt;
   logic [IDLE_W-1:0]     idle_cnt;
   logic                  receiving;

   fetch_state_t          fstate;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [ADDR_WIDTH-1:0] base;
   logic [TAP_W-1:0]      iss_cnt;
   logic                  tap_vld;
   logic [TAP_W-1:0]      tap_k;

   assign receiving     = (lstate == L_REQ) || (lstate == L_RECV);
   assign bus.load_busy = receiving;
   assign bus.rd_ready  = bus.loaded && (fstate == F_IDLE);
   assign base = ADDR_WIDTH'((int'(bus.rd_oc) * IN_CHANNELS + int'(bus.rd_ic)) * KERNEL_ELEM_NUM);

   // Stream words land at word_cnt, which is 0 while still waiting in REQ.
   always_ff @(posedge clk) begin
      if (receiving && bus.weight_valid)
         mem[word_cnt] <= bus.weight_data;
      ram_q <= mem[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lstate           <= L_IDLE;
         word_cnt         <= '0;
         idle_cnt         <= '0;
         bus.start_stream <= 1'b0;
         bus.loaded       <= 1'b0;
         bus.err_timeout  <= 1'b0;
         bus.err_overflow <= 1'b0;
      end else begin
         bus.start_stream <= 1'b0;
         case (lstate)
            L_IDLE, L_DONE: begin
               if (bus.load_start) begin
                  bus.start_stream <= 1'b1;
                  bus.loaded       <= 1'b0;
                  bus.err_timeout  <= 1'b0;
                  bus.err_overflow <= 1'b0;
                  word_cnt         <= '0;
                  idle_cnt         <= '0;
                  lstate           <= L_REQ;
               end
               if (bus.weight_valid)
                  bus.err_overflow <= 1'b1;
            end
            L_REQ, L_RECV: begin
               if (bus.weight_valid) begin
                  idle_cnt <= '0;
                  word_cnt <= word_cnt + 1'b1;
                  if (word_cnt == LAST_ADDR) begin
                     lstate     <= L_DONE;
                     bus.loaded <= 1'b1;
                  end else begin
                     lstate <= L_RECV;
                  end
               end else if (idle_cnt == IDLE_LIMIT) begin
                  bus.err_timeout <= 1'b1;
                  lstate          <= L_IDLE;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end
            default: lstate <= L_IDLE;
         endcase
      end
   end

   // Tap index trails the issued address by one cycle to match the RAM read latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         fstate        <= F_IDLE;
         rd_addr       <= '0;
         iss_cnt       <= '0;
         tap_vld       <= 1'b0;
         tap_k         <= '0;
         bus.win_valid <= 1'b0;
         bus.win_data  <= '0;
      end else begin
         tap_vld       <= (fstate == F_ISSUE);
         tap_k         <= iss_cnt;
         bus.win_valid <= 1'b0;
         if (tap_vld) begin
            for (int k = 0; k < KERNEL_ELEM_NUM; k++) begin
               if (tap_k == TAP_W'(k))
                  bus.win_data[k*DATA_WIDTH +: DATA_WIDTH] <= ram_q;
            end
         end
         case (fstate)
            F_IDLE: begin
               if (bus.rd_req && bus.rd_ready) begin
                  rd_addr <= base;
                  iss_cnt <= '0;
                  fstate  <= F_ISSUE;
               end
            end
            F_ISSUE: begin
               if (iss_cnt == LAST_TAP) begin
                  fstate <= F_DRAIN;
               end else begin
                  iss_cnt <= iss_cnt + 1'b1;
                  rd_addr <= rd_addr + 1'b1;
               end
            end
            F_DRAIN: begin
               bus.win_valid <= 1'b1;
               fstate        <= F_DONE;
            end
            F_DONE:  fstate <= F_IDLE;
            default: fstate <= F_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_conv_weight_loader.sv
// Bench for conv_weight_loader: streams weights, fetches windows and compares against a flat weight array.
module tb_conv_weight_loader;
   localparam int DW    = 16;
   localparam int IC    = 4;
   localparam int OC    = 64;
   localparam int KS    = 3;
   localparam int KN    = KS * KS;
   localparam int DEPTH = OC * IC * KN;
   localparam int TO    = 16;
   localparam int OCW   = $clog2(OC);
   localparam int ICW   = $clog2(IC);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   conv_weight_loader_if #(.DATA_WIDTH(DW), .IN_CHANNELS(IC), .OUT_CHANNELS(OC), .KERNEL_SIZE(KS)) bus();

   conv_weight_loader #(
      .DATA_WIDTH(DW), .IN_CHANNELS(IC), .OUT_CHANNELS(OC), .KERNEL_SIZE(KS), .START_TIMEOUT(TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [DW-1:0] ref_mem [DEPTH];
   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start_load;
      bus.load_start = 1'b1;
      tick;
      bus.load_start = 1'b0;
      check("start_stream_hi", 256'(bus.start_stream), 256'(1));
      check("busy_after_start", 256'(bus.load_busy), 256'(1));
      check("loaded_cleared", 256'(bus.loaded), 256'(0));
      check("timeout_cleared", 256'(bus.err_timeout), 256'(0));
      tick;
      check("start_stream_lo", 256'(bus.start_stream), 256'(0));
   endtask

   // mode 0: value n, no gaps; 1: value n, 3-cycle gap after every 7th word; 2: random data and gaps
   task automatic stream(input int mode, input int stop_at);
      logic [DW-1:0] d;
      int gap;
      for (int n = 0; n < DEPTH; n++) begin
         d = (mode == 2) ? DW'($urandom) : DW'(n);
         bus.weight_valid = 1'b1;
         bus.weight_data  = d;
         if (n == stop_at) begin
            rst = 1'b1;
            tick;
            rst = 1'b0;
            bus.weight_valid = 1'b0;
            return;
         end
         if (n == DEPTH - 1) check("loaded_before_last", 256'(bus.loaded), 256'(0));
         tick;
         ref_mem[n] = d;
         bus.weight_valid = 1'b0;
         gap = 0;
         if (mode == 1 && (n % 7) == 6) gap = 3;
         if (mode == 2 && $urandom_range(7) == 0) gap = int'($urandom_range(14, 1));
         if (n == DEPTH - 1) gap = 0;
         repeat (gap) tick;
      end
      check("loaded_after_last", 256'(bus.loaded), 256'(1));
      check("busy_after_load", 256'(bus.load_busy), 256'(0));
      check("no_timeout", 256'(bus.err_timeout), 256'(0));
      check("no_overflow", 256'(bus.err_overflow), 256'(0));
   endtask

   task automatic fetch(input int oc, input int ic);
      logic [KN*DW-1:0] exp_win;
      int  w, lat;
      bit  rdy_seen;
      w = 0;
      while (!bus.rd_ready && w < 20) begin
         tick;
         w++;
      end
      check("rd_ready_wait", 256'(bus.rd_ready), 256'(1));
      bus.rd_req = 1'b1;
      bus.rd_oc  = OCW'(oc);
      bus.rd_ic  = ICW'(ic);
      tick;
      bus.rd_req = 1'b0;
      lat = 0;
      rdy_seen = 1'b0;
      while (!bus.win_valid && lat < 30) begin
         if (bus.rd_ready) rdy_seen = 1'b1;
         tick;
         lat++;
      end
      if (bus.rd_ready) rdy_seen = 1'b1;
      check("fetch_latency", 256'(lat), 256'(10));
      check("rd_ready_in_fetch", 256'(rdy_seen), 256'(0));
      for (int k = 0; k < KN; k++)
         exp_win[k*DW +: DW] = ref_mem[(oc * IC + ic) * KN + k];
      check("win_data", 256'(bus.win_data), 256'(exp_win));
      tick;
      check("win_valid_pulse", 256'(bus.win_valid), 256'(0));
      check("win_data_hold", 256'(bus.win_data), 256'(exp_win));
      check("rd_ready_after", 256'(bus.rd_ready), 256'(1));
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit seen;
      rst              = 1'b1;
      bus.load_start   = 1'b0;
      bus.weight_valid = 1'b0;
      bus.weight_data  = '0;
      bus.rd_req       = 1'b0;
      bus.rd_oc        = '0;
      bus.rd_ic        = '0;
      repeat (3) tick;
      check("rst_start_stream", 256'(bus.start_stream), 256'(0));
      check("rst_loaded", 256'(bus.loaded), 256'(0));
      check("rst_load_busy", 256'(bus.load_busy), 256'(0));
      check("rst_err_timeout", 256'(bus.err_timeout), 256'(0));
      check("rst_err_overflow", 256'(bus.err_overflow), 256'(0));
      check("rst_rd_ready", 256'(bus.rd_ready), 256'(0));
      check("rst_win_valid", 256'(bus.win_valid), 256'(0));
      check("rst_win_data", 256'(bus.win_data), 256'(0));
      rst = 1'b0;
      tick;

      // a request before any load must be dropped
      bus.rd_req = 1'b1;
      tick;
      bus.rd_req = 1'b0;
      seen = 1'b0;
      repeat (14) begin
         if (bus.win_valid) seen = 1'b1;
         tick;
      end
      check("req_ignored", 256'(seen), 256'(0));

      start_load;
      stream(0, -1);
      fetch(5, 2);
      repeat (6) fetch(int'($urandom_range(OC - 1)), int'($urandom_range(IC - 1)));

      // no stream at all: timeout on the 16th idle cycle in REQ
      bus.load_start = 1'b1;
      tick;
      bus.load_start = 1'b0;
      repeat (TO - 1) tick;
      check("timeout_not_yet", 256'(bus.err_timeout), 256'(0));
      check("busy_before_timeout", 256'(bus.load_busy), 256'(1));
      tick;
      check("timeout_set", 256'(bus.err_timeout), 256'(1));
      check("timeout_idle", 256'(bus.load_busy), 256'(0));
      check("timeout_not_loaded", 256'(bus.loaded), 256'(0));

      start_load;
      stream(1, -1);
      fetch(63, 3);

      bus.weight_valid = 1'b1;
      bus.weight_data  = DW'($urandom);
      tick;
      bus.weight_valid = 1'b0;
      check("overflow_set", 256'(bus.err_overflow), 256'(1));
      check("overflow_loaded", 256'(bus.loaded), 256'(1));
      fetch(0, 0);

      start_load;
      stream(2, 1000);
      check("abort_loaded", 256'(bus.loaded), 256'(0));
      check("abort_rd_ready", 256'(bus.rd_ready), 256'(0));
      check("abort_load_busy", 256'(bus.load_busy), 256'(0));
      check("abort_start_stream", 256'(bus.start_stream), 256'(0));
      tick;

      start_load;
      stream(2, -1);
      repeat (8) fetch(int'($urandom_range(OC - 1)), int'($urandom_range(IC - 1)));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
